// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM served over valid/ready request and response channels.
// Latency: the response is valid LATENCY+1 cycles after the accept cycle. One transaction is in flight at a time.
// Backpressure: the response is held until resp_ready is seen. req_ready is high only in IDLE.
// Optional feature: define DMEM_ERR_EN to flag misaligned or out-of-range addresses through resp_err.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  // The counter starts at LATENCY-1, so the access happens LATENCY edges after the accept edge.
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    cap_write;
  logic                    cap_err;
  logic [ADDR_WIDTH-1:0]   cap_idx;
  logic [31:0]             cap_wdata;
  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    in_err;
  logic                    fire;
  logic                    acc_write;
  logic                    acc_err;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_wdata;

  assign accept = req_valid && req_ready;

`ifdef DMEM_ERR_EN
  assign in_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH+2] != '0);
`else
  // Without checking, the byte offset and the upper address bits alias onto the RAM.
  logic unused_addr_bits;
  assign in_err           = 1'b0;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:ADDR_WIDTH+2]};
`endif

  // Select the operands for the RAM access. A zero-latency accept uses the live request; otherwise the captured copy is used.
  always_comb begin
    acc_write = cap_write;
    acc_err   = cap_err;
    acc_idx   = cap_idx;
    acc_wdata = cap_wdata;
    fire      = 1'b0;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_err   = in_err;
      acc_idx   = req_addr[ADDR_WIDTH+1:2];
      acc_wdata = req_wdata;
      fire      = accept && (LATENCY == 0);
    end else if (state == WAIT) begin
      fire      = (cnt == 4'd0);
    end
  end

  // Control FSM. All channel outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
      cap_write  <= 1'b0;
      cap_err    <= 1'b0;
      cap_idx    <= '0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_err   <= in_err;
            cap_idx   <= req_addr[ADDR_WIDTH+1:2];
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
      // The result is loaded on the same edge that enters RESP. Stores and errors return zero data.
      if (fire) begin
        resp_rdata <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
        resp_err   <= acc_err;
      end
    end
  end

  // RAM: cleared on reset. A store is committed only on its access edge and only when the request is error-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (fire && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
